// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow errors and selectable first-word-fall-through reads.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AFULL_THRESH  = 12,
    parameter int unsigned AEMPTY_THRESH = 4,
    parameter bit          FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  walmost_full,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] One = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    // Wrap bit distinguishes full from empty when the address bits match.
    assign rempty = (wptr_q == rptr_q);
    assign wfull  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                    (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    assign walmost_full  = (32'(count_q) >= AFULL_THRESH);
    assign ralmost_empty = (32'(count_q) <= AEMPTY_THRESH);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    always_comb begin
        wr_ok  = write_enable & ~wfull;
        rd_ok  = read_enable & ~rempty;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) wptr_d = wptr_q + One;
        if (rd_ok) rptr_d = rptr_q + One;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + One;
            2'b01:   count_d = count_q - One;
            default: count_d = count_q;
        endcase
        // A new error event wins over a same-cycle clear.
        overflow_d  = (write_enable & wfull) | (overflow_q & ~clear_err);
        underflow_d = (read_enable & rempty) | (underflow_q & ~clear_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
    end

    if (FWFT) begin : g_fwft
        assign rdata = mem_q[rptr_q[ADDR_WIDTH-1:0]];
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rd_ok) begin
                rdata_q <= mem_q[rptr_q[ADDR_WIDTH-1:0]];
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read and an FWFT instance share stimulus,
// and a queue-based scoreboard supplies the expected data and flags.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          we, re, ce;
    logic [DW-1:0] wd;

    logic [DW-1:0] rdata, f_rdata;
    logic          wfull, rempty, wafull, raempty, ovf, udf;
    logic          f_wfull, f_rempty, f_wafull, f_raempty, f_ovf, f_udf;
    logic [AW:0]   count, f_count;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12),
                      .AEMPTY_THRESH(4), .FWFT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .write_enable(we), .wdata(wd), .read_enable(re),
        .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(wafull),
        .ralmost_empty(raempty), .count(count), .overflow(ovf), .underflow(udf),
        .clear_err(ce)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12),
                      .AEMPTY_THRESH(4), .FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rst(rst), .write_enable(we), .wdata(wd), .read_enable(re),
        .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .walmost_full(f_wafull),
        .ralmost_empty(f_raempty), .count(f_count), .overflow(f_ovf), .underflow(f_udf),
        .clear_err(ce)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] sb[$];
    int            mcount   = 0;
    bit            movf     = 1'b0;
    bit            mudf     = 1'b0;
    logic [DW-1:0] mrdata   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("count", 32'(count), mcount);
        check_eq("rempty", 32'(rempty), 32'(mcount == 0));
        check_eq("wfull", 32'(wfull), 32'(mcount == DEPTH));
        check_eq("walmost_full", 32'(wafull), 32'(mcount >= 12));
        check_eq("ralmost_empty", 32'(raempty), 32'(mcount <= 4));
        check_eq("overflow", 32'(ovf), 32'(movf));
        check_eq("underflow", 32'(udf), 32'(mudf));
        check_eq("rdata", 32'(rdata), 32'(mrdata));
        check_eq("f_count", 32'(f_count), mcount);
        check_eq("f_rempty", 32'(f_rempty), 32'(mcount == 0));
        check_eq("f_wfull", 32'(f_wfull), 32'(mcount == DEPTH));
        check_eq("f_overflow", 32'(f_ovf), 32'(movf));
        check_eq("f_underflow", 32'(f_udf), 32'(mudf));
        if (mcount > 0) check_eq("f_rdata_head", 32'(f_rdata), 32'(sb[0]));
    endtask

    // Called just after a falling edge: drive, advance the model, check after the rising edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bit wr_ok, rd_ok;
        we = w; wd = d; re = r; ce = c;
        wr_ok = w && (mcount < DEPTH);
        rd_ok = r && (mcount > 0);
        movf  = (w && mcount == DEPTH) || (movf && !c);
        mudf  = (r && mcount == 0) || (mudf && !c);
        if (rd_ok) mrdata = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        mcount = mcount + int'(wr_ok) - int'(rd_ok);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        we = 1'b0; re = 1'b0; ce = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; ce = 1'b0; wd = '0;
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // Fill to full, then push past full and exercise clear_err priority.
        for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h11, 0, 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h22, 0, 1);
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);

        // Underflow, then write+read on empty: write wins, read rejected.
        step(0, 8'h00, 1, 0);
        step(1, 8'h33, 1, 0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 0);

        // Pointer wrap-around.
        for (int rep = 0; rep < 4; rep++) begin
            for (int k = 0; k < 10; k++) step(1, 8'(8'h40 + rep * 16 + k), 0, 0);
            for (int k = 0; k < 10; k++) step(0, 8'h00, 1, 0);
        end

        // Simultaneous write+read at count 5 holds the count.
        for (int k = 0; k < 5; k++) step(1, 8'(8'h90 + k), 0, 0);
        step(1, 8'h9f, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 8'h00, 1, 0);

        // FWFT head visibility without a read, then pop.
        step(1, 8'hA5, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);

        // Random traffic.
        for (int k = 0; k < 80; k++)
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0));
        for (int k = 0; k < 80; k++)
            step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);

        // Asynchronous reset mid-stream at count 7.
        step(0, 8'h00, 0, 1);
        while (mcount > 0) step(0, 8'h00, 1, 0);
        for (int k = 0; k < 7; k++) step(1, 8'(8'hC0 + k), 0, 0);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        mcount = 0; movf = 1'b0; mudf = 1'b0; mrdata = '0;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        step(0, 8'h00, 0, 0);
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock FIFO, parametrised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Buffers byte/word streams between same-clock producer and consumer blocks in the datapath.
- Memory is an internal register array; no external RAM instance.

Parameters:
- DATA_WIDTH, 8, width of wdata/rdata.
- ADDR_WIDTH, 4, depth = 2**ADDR_WIDTH entries (16).
- AFULL_THRESH, 12, walmost_full asserted when count >= AFULL_THRESH.
- AEMPTY_THRESH, 4, ralmost_empty asserted when count <= AEMPTY_THRESH.
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_enable  input  1  write request.
- wdata  input  DATA_WIDTH  write data.
- read_enable  input  1  read request.
- rdata  output  DATA_WIDTH  read data.
- wfull  output  1  FIFO full.
- rempty  output  1  FIFO empty.
- walmost_full  output  1  count >= AFULL_THRESH.
- ralmost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- clear_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: wptr = rptr = 0, count = 0, rempty = 1, wfull = 0, walmost_full = 0, ralmost_empty = 1, overflow = 0, underflow = 0, rdata = 0. Memory contents are not reset.
- Reset mid-operation: all stored data is discarded immediately (asynchronously); the FIFO is empty on the first edge after rst deasserts.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits, binary; the low ADDR_WIDTH bits address memory; the MSB is a wrap bit.
  - rempty = (wptr == rptr).
  - wfull = MSBs differ and low bits equal.
  - Wrap-around happens naturally through modulo 2**(ADDR_WIDTH+1) increment.
- Accept rules, evaluated on pre-edge flags:
  - wr_ok = write_enable & ~wfull.
  - rd_ok = read_enable & ~rempty.
  - Full with both requested: the read is accepted, the write is rejected.
  - Empty with both requested: the write is accepted, the read is rejected.
  - Otherwise, simultaneous wr_ok and rd_ok both proceed and count is unchanged.
- count: registered; +1 on wr_ok only, -1 on rd_ok only. All flags are combinational decodes of the registered pointers/count, so each flag updates 1 cycle after the accepted operation.
- FWFT = 0 (registered read):
  - On rd_ok, rdata <= mem[rptr] at the edge; data is valid the cycle after the request.
  - rdata holds its value when no read is accepted.
- FWFT = 1:
  - rdata = mem[rptr[ADDR_WIDTH-1:0]] combinationally; the head word is visible whenever rempty = 0.
  - read_enable acknowledges/pops the current word.
  - First write into an empty FIFO: rempty falls and rdata shows the word 1 cycle after the write edge.
  - rdata is don't-care while rempty = 1.
- Errors:
  - overflow set on any edge with write_enable & wfull.
  - underflow set on any edge with read_enable & rempty.
  - Both are cleared by clear_err.
  - Set has priority over clear in the same cycle.
  - Rejected operations never alter the pointers or memory.
- Threshold flags: walmost_full and ralmost_empty may be asserted simultaneously when thresholds overlap; no constraint is imposed between the two thresholds.

Test Plan:
- Reset then idle: rempty = 1, wfull = 0, count = 0, ralmost_empty = 1, overflow = underflow = 0, rdata = 0.
- FWFT = 0, write 0x01..0x10 on 16 consecutive cycles -> wfull = 1, count = 16, walmost_full from count = 12; then 16 reads -> rdata 0x01..0x10 each 1 cycle after its request, rempty = 1 after the last read.
- 17th write while full -> overflow = 1, count stays 16, data unchanged; clear_err pulse -> overflow = 0; write_enable with clear_err on a full FIFO -> overflow stays 1.
- Read on empty FIFO -> underflow = 1, rptr unchanged; simultaneous write+read on empty -> count = 1, read rejected.
- Wrap-around: 10 writes, 10 reads, repeated 4 times (pointers wrap twice) -> data order preserved, count returns to 0; simultaneous write+read at count = 5 -> count stays 5.
- FWFT = 1: write 0xA5 to empty FIFO -> next cycle rempty = 0, rdata = 0xA5 with no read; read_enable -> rempty = 1 the following cycle; assert rst mid-stream at count = 7 -> count = 0, rempty = 1 immediately.
